// File: rtl/btb_set_assoc_if.sv
// Fetch-lookup and execute-training bundle for the branch target buffer.
// Fetch and execute sides drive the master modport; the buffer takes the slave modport.
interface btb_set_assoc_if #(
    parameter int XLEN   = 32,
    parameter int NUM_RD = 2
);
    logic [NUM_RD-1:0]      lookup_valid;
    logic [NUM_RD*XLEN-1:0] lookup_pc;
    logic [NUM_RD-1:0]      hit;
    logic [NUM_RD*XLEN-1:0] pred_target;
    logic [NUM_RD-1:0]      is_branch;
    logic [NUM_RD-1:0]      is_call;
    logic [NUM_RD-1:0]      is_ret;
    logic                   update_en;
    logic [XLEN-1:0]        update_pc;
    logic [XLEN-1:0]        update_target;
    logic [1:0]             update_type;
    logic                   inval_en;
    logic [XLEN-1:0]        inval_pc;

    modport master (
        output lookup_valid, lookup_pc, update_en, update_pc, update_target,
               update_type, inval_en, inval_pc,
        input  hit, pred_target, is_branch, is_call, is_ret
    );

    modport slave (
        input  lookup_valid, lookup_pc, update_en, update_pc, update_target,
               update_type, inval_en, inval_pc,
        output hit, pred_target, is_branch, is_call, is_ret
    );
endinterface

// File: rtl/btb_set_assoc.sv
// Set-associative BTB with tree-PLRU replacement; lookups registered with 1-cycle latency.
// No backpressure: every lookup, update and invalidate is accepted in the cycle presented.
module btb_set_assoc #(
    parameter int XLEN     = 32,
    parameter int SET_BITS = 4,
    parameter int WAYS     = 4,
    parameter int NUM_RD   = 2,
    parameter int TAG_W    = XLEN - SET_BITS - 2
) (
    input logic            CLK,
    input logic            reset,
    btb_set_assoc_if.slave bus
);
    localparam int SETS = 1 << SET_BITS;
    localparam int WB   = $clog2(WAYS);

    typedef logic [SET_BITS-1:0] set_t;
    typedef logic [TAG_W-1:0]    tag_t;
    typedef logic [WB-1:0]       way_t;
    typedef logic [WAYS-2:0]     plru_t;

    logic [WAYS-1:0] valid   [SETS];
    tag_t            tag_arr [SETS][WAYS];
    logic [XLEN-1:0] tgt_arr [SETS][WAYS];
    logic [1:0]      typ_arr [SETS][WAYS];
    plru_t           plru     [SETS];
    plru_t           plru_nxt [SETS];

    // Heap-ordered tree: node n has children 2n+1 (lower ways) and 2n+2.
    function automatic way_t plru_victim(input plru_t bits);
        way_t w;
        way_t node;
        w    = '0;
        node = '0;
        for (int l = 0; l < WB; l++) begin
            w[WB-1-l] = bits[node];
            node      = way_t'(2 * node + 1 + bits[node]);
        end
        return w;
    endfunction

    function automatic plru_t plru_touch(input plru_t bits, input way_t w);
        plru_t b;
        way_t  node;
        b    = bits;
        node = '0;
        for (int l = 0; l < WB; l++) begin
            b[node] = ~w[WB-1-l];
            node    = way_t'(2 * node + 1 + w[WB-1-l]);
        end
        return b;
    endfunction

    set_t              lk_set   [NUM_RD];
    tag_t              lk_tag   [NUM_RD];
    logic [WAYS-1:0]   lk_match [NUM_RD];
    way_t              lk_way   [NUM_RD];
    logic [NUM_RD-1:0] lk_hit;
    logic [2*NUM_RD-1:0] unused_lk_lsb;

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            lk_set[i] = bus.lookup_pc[i*XLEN+2 +: SET_BITS];
            lk_tag[i] = bus.lookup_pc[i*XLEN+SET_BITS+2 +: TAG_W];
            unused_lk_lsb[2*i +: 2] = bus.lookup_pc[i*XLEN +: 2];
            lk_way[i] = '0;
            for (int w = 0; w < WAYS; w++) begin
                lk_match[i][w] = valid[lk_set[i]][w] && (tag_arr[lk_set[i]][w] == lk_tag[i]);
                if (lk_match[i][w]) lk_way[i] = way_t'(w);
            end
            lk_hit[i] = bus.lookup_valid[i] && (|lk_match[i]);
        end
    end

    wire unused_pc_bits = ^{unused_lk_lsb, bus.update_pc[1:0], bus.inval_pc[1:0]};

    set_t            u_set, i_set;
    tag_t            u_tag, i_tag;
    logic [WAYS-1:0] u_match, i_match;
    way_t            u_hit_way, i_way, free_way, u_way;
    logic            has_free, u_do, i_do;

    always_comb begin
        u_set     = bus.update_pc[SET_BITS+1:2];
        u_tag     = bus.update_pc[XLEN-1:SET_BITS+2];
        i_set     = bus.inval_pc[SET_BITS+1:2];
        i_tag     = bus.inval_pc[XLEN-1:SET_BITS+2];
        u_hit_way = '0;
        i_way     = '0;
        free_way  = '0;
        has_free  = 1'b0;
        // Scanning downward leaves the lowest-numbered free way selected.
        for (int w = WAYS - 1; w >= 0; w--) begin
            u_match[w] = valid[u_set][w] && (tag_arr[u_set][w] == u_tag);
            i_match[w] = valid[i_set][w] && (tag_arr[i_set][w] == i_tag);
            if (u_match[w]) u_hit_way = way_t'(w);
            if (i_match[w]) i_way = way_t'(w);
            if (!valid[u_set][w]) begin
                free_way = way_t'(w);
                has_free = 1'b1;
            end
        end
        i_do  = bus.inval_en && (|i_match);
        u_do  = bus.update_en && !(bus.inval_en && (u_set == i_set) && (u_tag == i_tag));
        u_way = (|u_match) ? u_hit_way : (has_free ? free_way : plru_victim(plru[u_set]));
    end

    always_comb begin
        plru_nxt = plru;
        for (int i = 0; i < NUM_RD; i++) begin
            if (lk_hit[i]) plru_nxt[lk_set[i]] = plru_touch(plru_nxt[lk_set[i]], lk_way[i]);
        end
        if (u_do) plru_nxt[u_set] = plru_touch(plru_nxt[u_set], u_way);
    end

    always_ff @(posedge CLK) begin
        for (int s = 0; s < SETS; s++) begin
            plru[s] <= reset ? '0 : plru_nxt[s];
        end
    end

    // An invalidate and an allocation may land on the same way; the allocation wins.
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) valid[s] <= '0;
        end else begin
            if (i_do) valid[i_set][i_way] <= 1'b0;
            if (u_do) valid[u_set][u_way] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (u_do) begin
            tag_arr[u_set][u_way] <= u_tag;
            tgt_arr[u_set][u_way] <= bus.update_target;
            typ_arr[u_set][u_way] <= bus.update_type;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            bus.hit         <= '0;
            bus.pred_target <= '0;
            bus.is_branch   <= '0;
            bus.is_call     <= '0;
            bus.is_ret      <= '0;
        end else begin
            for (int i = 0; i < NUM_RD; i++) begin
                bus.hit[i]                     <= lk_hit[i];
                bus.pred_target[i*XLEN +: XLEN] <= lk_hit[i] ? tgt_arr[lk_set[i]][lk_way[i]] : '0;
                bus.is_branch[i] <= lk_hit[i] && (typ_arr[lk_set[i]][lk_way[i]] == 2'b01);
                bus.is_call[i]   <= lk_hit[i] && (typ_arr[lk_set[i]][lk_way[i]] == 2'b10);
                bus.is_ret[i]    <= lk_hit[i] && (typ_arr[lk_set[i]][lk_way[i]] == 2'b11);
            end
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_chk
        a_lk_onehot: assert property (@(posedge CLK) disable iff (reset) $onehot0(lk_match[g]));
    end
    a_upd_onehot: assert property (@(posedge CLK) disable iff (reset) $onehot0(u_match));
endmodule

// File: doc/btb_set_assoc.md
Name: btb_set_assoc

Overview:
Parametrised set-associative branch target buffer for the out-of-order core's fetch stage. It serves NUM_RD fetch slots per cycle with registered one-cycle lookups and tree pseudo-LRU replacement. It is trained from execute with update and invalidate requests, and classifies each hit as branch, call or return.

Parameters:
XLEN, 32, address and target width
SET_BITS, 4, index bits; sets = 2^SET_BITS; index = pc[SET_BITS+1:2]
WAYS, 4, associativity; power of two, 2..8
NUM_RD, 2, lookup ports (fetch slots)
TAG_W, XLEN-SET_BITS-2, tag = pc[XLEN-1:SET_BITS+2]

Ports:
CLK  in  1  clock
reset  in  1  synchronous, active-high
lookup_valid  in  NUM_RD  per-slot lookup request
lookup_pc  in  NUM_RD*XLEN  slot i at [i*XLEN +: XLEN]
hit  out  NUM_RD  registered hit per slot
pred_target  out  NUM_RD*XLEN  registered target per slot
is_branch  out  NUM_RD  hit entry is a conditional branch
is_call  out  NUM_RD  hit entry is a call
is_ret  out  NUM_RD  hit entry is a return
update_en  in  1  train/allocate request
update_pc  in  XLEN  PC of the resolved control-flow instruction
update_target  in  XLEN  resolved target
update_type  in  2  00 jump, 01 branch, 10 call, 11 ret
inval_en  in  1  invalidate request
inval_pc  in  XLEN  PC to invalidate

Behaviour:
- Reset (synchronous): clear all valid bits, all PLRU bits and all outputs to 0 at the same edge. Reset mid-lookup drops the lookup; the next cycle shows hit=0.
- Entry fields: tag, target, type, valid. Each set holds WAYS-1 tree-PLRU bits.
- Lookup latency is 1 cycle. The edge after lookup_valid[i] registers the slot-i outputs. hit[i] = lookup_valid[i] AND some valid way has a matching tag.
- On a miss, or when lookup_valid[i]=0: hit, pred_target and the type flags of slot i are 0.
- Type flags decode the hit entry's type. Jump (00) asserts only hit.
- Ways never hold duplicate tags within a set. A multi-match is impossible by construction; verification asserts it.
- Read-before-write: a lookup in the same cycle as an update or invalidate to that set sees the pre-write contents. The write is visible to lookups presented the following cycle.
- Update, tag hit: overwrite target and type in the hitting way and touch it in PLRU.
- Update, miss: pick the lowest-numbered invalid way. If the set is full, pick the PLRU victim. Write the entry valid and touch it.
- PLRU, per node: 0 = victim is in the left (lower ways) subtree, 1 = victim is in the right subtree. A touch sets every node on the path to point away from the touched way.
- Lookup hits touch PLRU. Touches apply in port order 0..NUM_RD-1, with the update touch applied last, all in one cycle.
- Invalidate: clear valid on the matching way; PLRU is unchanged. A miss is a no-op.
- inval_en and update_en in the same cycle for the same set and tag: the invalidate wins and the update is dropped.
- inval_en and update_en for different sets/tags: both take effect.
- Any number of ports may look up the same set or the same PC in one cycle. All get identical results.

Test Plan:
- Reset, then lookup 0x0000_0040 on both slots -> hit=00, pred_target=0, all flags 0 the next cycle.
- Update pc=0x100, target=0x2000, type=10; next cycle lookup slot0=0x100, slot1=0x104 -> hit=01, slot0 target 0x2000, is_call[0]=1, slot1 all 0.
- Same-cycle update pc=0x200/target 0x3000 plus lookup 0x200 -> hit=0 that result. Repeat the lookup one cycle later -> hit=1, target 0x3000.
- Fill set 0 with 0x000, 0x040, 0x080, 0x0C0 (targets 0xA0..0xA3). Look up 0x000 (touch way0). Update 0x100 -> 0x080 evicted (way2).
  - Lookups of 0x000, 0x040, 0x0C0, 0x100 hit; 0x080 misses.
  - Without the touch, 0x000 is evicted instead.
- Update 0x040 type 11 target 0x44, then inval_en and update_en both on 0x040 -> next lookup misses. Re-update 0x040 -> it reuses the freed way (lowest invalid), and no other entry is evicted.
- Assert reset during a cycle with active lookups and a pending update -> outputs 0 at that edge. The updated PC misses afterwards.
